dff_bank_arbiter: RTL

//  Owns a bank of DEPTH x WIDTH edge-triggered storage registers and shares it between two requesters, A and B.

---
 rtl/dff_bank_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Owns a DEPTH x WIDTH register bank and shares it between requesters A and B
//   through a registered request/grant handshake. Contention from IDLE is
//   resolved round-robin, and each tenure is bounded by MAX_HOLD accesses
//   while the other side is waiting.
//
// Ports
//   Clk, Rst_n            rising-edge clock, synchronous active-low reset
//   ReqA/WeA/AddrA/DinA   requester A: request, write enable, address, write data
//   ReqB/WeB/AddrB/DinB   requester B: same as A
//   GntA, GntB            ownership of the bank this cycle (never both high)
//   Dout                  read data, held while DoutValid is low
//   DoutValid             Dout carries the previous cycle's read result
//   DoutSrc               0 = that read came from A, 1 = from B
module dff_bank_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqA,
    input  logic              WeA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [WIDTH-1:0]  DinA,
    output logic              GntA,
    input  logic              ReqB,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [WIDTH-1:0]  DinB,
    output logic              GntB,
    output logic [WIDTH-1:0]  Dout,
    output logic              DoutValid,
    output logic              DoutSrc
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  bank [DEPTH];
    logic [CNT_W-1:0]  hold_cnt;
    logic              ptr_b;        // 1 = contention from IDLE goes to B

    // Signals of the current owner, and the request of the waiting side
    logic              act_req;
    logic              act_we;
    logic [ADDR_W-1:0] act_addr;
    logic [WIDTH-1:0]  act_din;
    logic              oth_req;
    logic              addr_ok;
    logic [CNT_W-1:0]  cnt_next;

    assign GntA = (state == OWN_A);
    assign GntB = (state == OWN_B);

    always_comb begin
        act_req  = 1'b0;
        act_we   = 1'b0;
        act_addr = '0;
        act_din  = '0;
        oth_req  = 1'b0;
        if (state == OWN_A) begin
            act_req  = ReqA;
            act_we   = WeA;
            act_addr = AddrA;
            act_din  = DinA;
            oth_req  = ReqB;
        end else if (state == OWN_B) begin
            act_req  = ReqB;
            act_we   = WeB;
            act_addr = AddrB;
            act_din  = DinB;
            oth_req  = ReqA;
        end
    end

    assign addr_ok  = ({1'b0, act_addr} < DEPTH_EXT);
    // Counter saturates at the limit so a lone owner keeps the bank indefinitely
    // yet yields at the very next access once the other side shows up.
    assign cnt_next = (hold_cnt == HOLD_LIMIT) ? HOLD_LIMIT : hold_cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= IDLE;
            bank      <= '{default: '0};
            hold_cnt  <= '0;
            ptr_b     <= 1'b0;
            Dout      <= '0;
            DoutValid <= 1'b0;
            DoutSrc   <= 1'b0;
        end else begin
            DoutValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqA && (!ReqB || !ptr_b)) begin
                        state    <= OWN_A;
                        ptr_b    <= 1'b1;
                        hold_cnt <= '0;
                    end else if (ReqB) begin
                        state    <= OWN_B;
                        ptr_b    <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                OWN_A, OWN_B: begin
                    if (act_req) begin
                        if (act_we) begin
                            if (addr_ok) begin
                                bank[act_addr] <= act_din;
                            end
                        end else begin
                            Dout      <= addr_ok ? bank[act_addr] : '0;
                            DoutValid <= 1'b1;
                            DoutSrc   <= (state == OWN_B);
                        end
                        if (cnt_next == HOLD_LIMIT && oth_req) begin
                            state    <= (state == OWN_A) ? OWN_B : OWN_A;
                            ptr_b    <= (state == OWN_B);
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= cnt_next;
                        end
                    end else begin
                        hold_cnt <= '0;
                        if (oth_req) begin
                            state <= (state == OWN_A) ? OWN_B : OWN_A;
                            ptr_b <= (state == OWN_B);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
